// File: rtl/eda_regional_max_engine_if.sv
// Host-side bus of the regional-maximum engine: image write port, start/clear
// controls, result read port and status outputs.
interface eda_regional_max_engine_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 6
);
    logic                   write_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [PIXEL_WIDTH-1:0] pixel_in;
    logic [ADDR_WIDTH-1:0]  center_addr;
    logic                   new_pixel;
    logic                   clear;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [1:0]             rd_state;
    logic                   busy;
    logic                   done;
    logic                   is_max;

    modport master (
        output write_en, wr_addr, pixel_in, center_addr, new_pixel, clear, rd_addr,
        input  rd_state, busy, done, is_max
    );

    modport slave (
        input  write_en, wr_addr, pixel_in, center_addr, new_pixel, clear, rd_addr,
        output rd_state, busy, done, is_max
    );
endinterface

// File: rtl/eda_regional_max_engine.sv
// Regional-maximum classifier: flood-fills the 8-connected equal plateau around a
// center pixel by repeated row-major sweeps, then labels it maximum / not maximum.
module eda_regional_max_engine #(
    parameter int M            = 6,
    parameter int N            = 6,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int I_WIDTH      = $clog2(M),
    parameter int J_WIDTH      = $clog2(N),
    parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    eda_regional_max_engine_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    logic [PIXEL_WIDTH-1:0] img_r  [M][N];
    logic [1:0]             iter_r [M][N];

    state_t             state_r;
    logic [I_WIDTH-1:0] row_r;
    logic [J_WIDTH-1:0] col_r;
    logic [I_WIDTH-1:0] cen_row_r;
    logic [J_WIDTH-1:0] cen_col_r;
    logic               changed_r;
    logic               nonmax_r;
    logic               busy_r;
    logic               done_r;
    logic               is_max_r;

    logic [I_WIDTH-1:0] wr_row_s, cen_row_s, rd_row_s;
    logic [J_WIDTH-1:0] wr_col_s, cen_col_s, rd_col_s;
    logic               wr_ok_s, cen_ok_s, rd_ok_s;
    logic               last_s;

    logic [I_WIDTH-1:0]     nrow_s [3];
    logic [J_WIDTH-1:0]     ncol_s [3];
    logic [2:0]             row_ok_s;
    logic [2:0]             col_ok_s;
    logic [PIXEL_WIDTH-1:0] cur_pix_s;
    logic                   cur_member_s;
    logic [WINDOW_WIDTH-1:0] nbr_ok_s;
    logic [PIXEL_WIDTH-1:0] nbr_pix_s [WINDOW_WIDTH];
    logic [1:0]             nbr_st_s  [WINDOW_WIDTH];
    logic [WINDOW_WIDTH-1:0] grow_s;
    logic                   higher_s;
    logic                   changed_now_s;

    function automatic logic row_in(input logic [I_WIDTH-1:0] r);
        return ({1'b0, r} < (I_WIDTH + 1)'(M));
    endfunction

    function automatic logic col_in(input logic [J_WIDTH-1:0] c);
        return ({1'b0, c} < (J_WIDTH + 1)'(N));
    endfunction

    assign wr_row_s  = bus.wr_addr[ADDR_WIDTH-1:J_WIDTH];
    assign wr_col_s  = bus.wr_addr[J_WIDTH-1:0];
    assign cen_row_s = bus.center_addr[ADDR_WIDTH-1:J_WIDTH];
    assign cen_col_s = bus.center_addr[J_WIDTH-1:0];
    assign rd_row_s  = bus.rd_addr[ADDR_WIDTH-1:J_WIDTH];
    assign rd_col_s  = bus.rd_addr[J_WIDTH-1:0];
    assign wr_ok_s   = row_in(wr_row_s) && col_in(wr_col_s);
    assign cen_ok_s  = row_in(cen_row_s) && col_in(cen_col_s);
    assign rd_ok_s   = row_in(rd_row_s) && col_in(rd_col_s);
    assign last_s    = (row_r == I_WIDTH'(M - 1)) && (col_r == J_WIDTH'(N - 1));

    // Neighbour row/column indices; off-image neighbours fold back onto the scan pixel
    always_comb begin
        row_ok_s[0] = (row_r != '0);
        row_ok_s[1] = 1'b1;
        row_ok_s[2] = (row_r != I_WIDTH'(M - 1));
        col_ok_s[0] = (col_r != '0);
        col_ok_s[1] = 1'b1;
        col_ok_s[2] = (col_r != J_WIDTH'(N - 1));
        nrow_s[0]   = row_ok_s[0] ? (row_r - I_WIDTH'(1)) : row_r;
        nrow_s[1]   = row_r;
        nrow_s[2]   = row_ok_s[2] ? (row_r + I_WIDTH'(1)) : row_r;
        ncol_s[0]   = col_ok_s[0] ? (col_r - J_WIDTH'(1)) : col_r;
        ncol_s[1]   = col_r;
        ncol_s[2]   = col_ok_s[2] ? (col_r + J_WIDTH'(1)) : col_r;
    end

    assign cur_pix_s    = img_r[row_r][col_r];
    assign cur_member_s = (iter_r[row_r][col_r] == 2'd1);

    // Gather the 3x3 window around the scan pixel
    always_comb begin
        for (int k = 0; k < WINDOW_WIDTH; k++) begin
            nbr_ok_s[k]  = cur_member_s && row_ok_s[k / 3] && col_ok_s[k % 3] && (k != 4);
            nbr_pix_s[k] = img_r[nrow_s[k / 3]][ncol_s[k % 3]];
            nbr_st_s[k]  = iter_r[nrow_s[k / 3]][ncol_s[k % 3]];
        end
    end

    // Plateau growth and strictly-higher-neighbour detection for the scan pixel
    always_comb begin
        higher_s = 1'b0;
        grow_s   = '0;
        for (int k = 0; k < WINDOW_WIDTH; k++) begin
            grow_s[k] = nbr_ok_s[k] && (nbr_pix_s[k] == cur_pix_s) && (nbr_st_s[k] == 2'd0);
            higher_s  = higher_s | (nbr_ok_s[k] && (nbr_pix_s[k] > cur_pix_s));
        end
    end

    assign changed_now_s = changed_r | (|grow_s);

    // Image memory: host writes only while idle and in range
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    img_r[i][j] <= '0;
                end
            end
        end else if (bus.write_en && (state_r == ST_IDLE) && wr_ok_s) begin
            img_r[wr_row_s][wr_col_s] <= bus.pixel_in;
        end
    end

    // Control FSM together with the iterated memory it owns
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    iter_r[i][j] <= 2'd0;
                end
            end
            state_r   <= ST_IDLE;
            row_r     <= '0;
            col_r     <= '0;
            cen_row_r <= '0;
            cen_col_r <= '0;
            changed_r <= 1'b0;
            nonmax_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            is_max_r  <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    iter_r[i][j] <= 2'd0;
                end
            end
            state_r   <= ST_IDLE;
            row_r     <= '0;
            col_r     <= '0;
            changed_r <= 1'b0;
            nonmax_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            is_max_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.new_pixel && cen_ok_s) begin
                        cen_row_r <= cen_row_s;
                        cen_col_r <= cen_col_s;
                        busy_r    <= 1'b1;
                        // A center already classified answers from the stored label
                        if (iter_r[cen_row_s][cen_col_s][1]) begin
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
                            is_max_r <= (iter_r[cen_row_s][cen_col_s] == 2'd2);
                        end else begin
                            state_r  <= ST_INIT;
                            is_max_r <= 1'b0;
                        end
                    end
                end
                ST_INIT: begin
                    iter_r[cen_row_r][cen_col_r] <= 2'd1;
                    changed_r <= 1'b0;
                    nonmax_r  <= 1'b0;
                    row_r     <= '0;
                    col_r     <= '0;
                    state_r   <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    for (int k = 0; k < WINDOW_WIDTH; k++) begin
                        if (grow_s[k]) begin
                            iter_r[nrow_s[k / 3]][ncol_s[k % 3]] <= 2'd1;
                        end
                    end
                    nonmax_r <= nonmax_r | higher_s;
                    if (last_s) begin
                        row_r     <= '0;
                        col_r     <= '0;
                        changed_r <= 1'b0;
                        state_r   <= changed_now_s ? ST_SWEEP : ST_FINAL;
                    end else begin
                        changed_r <= changed_now_s;
                        if (col_r == J_WIDTH'(N - 1)) begin
                            col_r <= '0;
                            row_r <= row_r + I_WIDTH'(1);
                        end else begin
                            col_r <= col_r + J_WIDTH'(1);
                        end
                    end
                end
                ST_FINAL: begin
                    if (iter_r[row_r][col_r] == 2'd1) begin
                        iter_r[row_r][col_r] <= nonmax_r ? 2'd3 : 2'd2;
                    end
                    if (last_s) begin
                        row_r    <= '0;
                        col_r    <= '0;
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                        is_max_r <= !nonmax_r;
                    end else if (col_r == J_WIDTH'(N - 1)) begin
                        col_r <= '0;
                        row_r <= row_r + I_WIDTH'(1);
                    end else begin
                        col_r <= col_r + J_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_state = rd_ok_s ? iter_r[rd_row_s][rd_col_s] : 2'd0;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.is_max   = is_max_r;

endmodule

// File: tb/tb_eda_regional_max_engine.sv
// Directed bench for eda_regional_max_engine: table of image/center vectors with
// hand-derived latency, verdict and label maps, plus clear/write-guard sequences.
module tb_eda_regional_max_engine;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    eda_regional_max_engine_if #(.PIXEL_WIDTH(8), .ADDR_WIDTH(6)) bus ();

    eda_regional_max_engine #(.M(6), .N(6), .PIXEL_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int img_id;
        bit reload;
        int cr;
        int cc;
        int exp_lat;
        bit exp_max;
        int map_id;
    } vec_t;

    vec_t vecs [8];

    function automatic bit in_quad(input int r, input int c);
        return (r >= 1) && (r <= 2) && (c >= 1) && (c <= 2);
    endfunction

    function automatic logic [7:0] img_px(input int id, input int r, input int c);
        case (id)
            0:       return (r == 2 && c == 3) ? 8'd9 : 8'd0;
            1:       return in_quad(r, c) ? 8'd5 : 8'd1;
            2:       return (r == 3 && c == 3) ? 8'd7 : (in_quad(r, c) ? 8'd5 : 8'd1);
            3:       return 8'd0;
            4:       return (r == 0 && c == 0) ? 8'd8 : 8'd3;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_cell(input int map_id, input int r, input int c);
        case (map_id)
            0:       return (r == 2 && c == 3) ? 2'd2 : 2'd0;
            1:       return in_quad(r, c) ? 2'd2 : 2'd0;
            2:       return in_quad(r, c) ? 2'd3 : 2'd0;
            3:       return 2'd2;
            4:       return (r == 0 && c == 0) ? 2'd2 : 2'd0;
            5:       return (r == 0 && c == 0) ? 2'd2 : 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_map(input string name, input int map_id);
        int bad;
        int br;
        int bc;
        int bv;
        int be;
        bad = 0;
        br = 0; bc = 0; bv = 0; be = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                bus.rd_addr = {r[2:0], c[2:0]};
                #1;
                if (bus.rd_state !== exp_cell(map_id, r, c)) begin
                    if (bad == 0) begin
                        br = r; bc = c;
                        bv = int'(bus.rd_state);
                        be = int'(exp_cell(map_id, r, c));
                    end
                    bad++;
                end
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d cells wrong, first (%0d,%0d) got %0d expected %0d",
                     name, bad, br, bc, bv, be);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic load_image(input int id);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                bus.write_en = 1'b1;
                bus.wr_addr  = {r[2:0], c[2:0]};
                bus.pixel_in = img_px(id, r, c);
            end
        end
        @(negedge clk);
        bus.write_en = 1'b0;
        pulse_clear();
    endtask

    // Returns just after edge E0 (the edge that samples new_pixel)
    task automatic do_start(input int r, input int c);
        @(negedge clk);
        bus.center_addr = {r[2:0], c[2:0]};
        bus.new_pixel   = 1'b1;
        @(posedge clk);
        #1;
        bus.new_pixel   = 1'b0;
    endtask

    task automatic run(input int r, input int c, input bit poke,
                       output int lat, output int got_max);
        do_start(r, c);
        lat = -1;
        if (bus.done) lat = 0;
        for (int off = 1; off <= 300 && lat < 0; off++) begin
            if (poke && off <= 4) begin
                bus.write_en = 1'b1;
                bus.wr_addr  = off[0] ? {3'd2, 3'd4} : {3'd2, 3'd3};
                bus.pixel_in = off[0] ? 8'd20 : 8'd0;
            end else begin
                bus.write_en = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) lat = off;
        end
        bus.write_en = 1'b0;
        got_max = int'(bus.is_max);
    endtask

    task automatic check_pulse_end(input string name);
        @(posedge clk);
        #1;
        check(name, int'({bus.done, bus.busy}), 0);
    endtask

    initial begin
        int lat;
        int got_max;
        int seen;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{0, 1'b1, 2, 3,  73, 1'b1, 0};
        vecs[1] = '{1, 1'b1, 1, 2, 109, 1'b1, 1};
        vecs[2] = '{2, 1'b1, 1, 1, 109, 1'b0, 2};
        vecs[3] = '{3, 1'b1, 0, 2, 109, 1'b1, 3};
        vecs[4] = '{3, 1'b0, 5, 5,   0, 1'b1, 3};
        vecs[5] = '{4, 1'b1, 0, 0,  73, 1'b1, 4};
        vecs[6] = '{4, 1'b0, 0, 1, 109, 1'b0, 5};
        vecs[7] = '{4, 1'b0, 3, 4,   0, 1'b0, 5};

        reset_n         = 1'b0;
        bus.write_en    = 1'b0;
        bus.wr_addr     = 6'd0;
        bus.pixel_in    = 8'd0;
        bus.center_addr = 6'd0;
        bus.new_pixel   = 1'b0;
        bus.clear       = 1'b0;
        bus.rd_addr     = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_is_max", int'(bus.is_max), 0);
        check_map("reset_map", 99);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].reload) load_image(vecs[i].img_id);
            run(vecs[i].cr, vecs[i].cc, 1'b0, lat, got_max);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_is_max", i), got_max, int'(vecs[i].exp_max));
            check_pulse_end($sformatf("v%0d_pulse_end", i));
            check_map($sformatf("v%0d_map", i), vecs[i].map_id);
        end

        // Writes attempted while busy must not reach the image
        load_image(0);
        run(2, 3, 1'b1, lat, got_max);
        check("guard_run_latency", lat, 73);
        check("guard_run_is_max", got_max, 1);
        pulse_clear();
        #1;
        check("clear_idle_is_max", int'(bus.is_max), 0);
        check_map("clear_idle_map", 99);
        run(2, 3, 1'b0, lat, got_max);
        check("guard_rerun_latency", lat, 73);
        check("guard_rerun_is_max", got_max, 1);
        check_map("guard_rerun_map", 0);

        // Clear in the middle of a sweep aborts the run
        load_image(3);
        do_start(0, 0);
        check("start_busy", int'(bus.busy), 1);
        repeat (20) @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check_map("abort_map", 99);
        seen = 0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("abort_no_done", seen, 0);
        run(0, 0, 1'b0, lat, got_max);
        check("after_abort_latency", lat, 109);
        check("after_abort_is_max", got_max, 1);
        check_map("after_abort_map", 3);

        // Out-of-range center is ignored
        do_start(6, 0);
        check("oor_center_busy", int'(bus.busy), 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check("oor_center_quiet", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
